clint_timer: RTL

- Core-local interruptor (CLINT) peripheral, decoded in the window clint_base_addr..clint_top_addr of the shared configure package.
- Holds the RISC-V machine timer (mtime, mtimecmp) and the software-interrupt bit (msip).
- mtime advances on an RTC tick derived from the system clock through clk_divider_rtc.
- Drives timer_irq and soft_irq to the core CSR stage.

---
 rtl/clint_pkg.sv | 23 ++
 rtl/clint_rtc_tick.sv | 30 +++
 rtl/clint_timer.sv | 84 ++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, default configuration values and the byte-merge helper
// shared by the CLINT timer block.
package clint_pkg;

   localparam int          CLK_DIVIDER_RTC = 380;
   localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;

   localparam logic [15:0] MSIP_OFF        = 16'h0000;
   localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
   localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
   localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: free-running RTC divider; pulses rtc_tick on the edge where the
// RTC level rises, i.e. once every 2*(RTC_DIV+1) system clocks.
module clint_rtc_tick #(
   parameter int RTC_DIV = 380
) (
   input  logic reset,
   input  logic clock,
   output logic rtc_tick
);

   localparam int W = (RTC_DIV > 0) ? $clog2(RTC_DIV + 1) : 1;

   logic [W-1:0] count;
   logic         level;
   logic         wrap;

   assign wrap     = (count == W'(RTC_DIV));
   assign rtc_tick = wrap & ~level;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         level <= 1'b0;
      end else begin
         count <= wrap ? '0 : count + W'(1);
         level <= wrap ? ~level : level;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor holding mtime, mtimecmp and msip, with a
// single-cycle bus response and registered timer/software interrupt outputs.
module clint_timer
   import clint_pkg::*;
#(
   parameter int          RTC_DIV   = CLK_DIVIDER_RTC,
   parameter logic [31:0] BASE_ADDR = CLINT_BASE_ADDR
) (
   input  logic        reset,
   input  logic        clock,
   input  logic        clint_valid,
   input  logic        clint_instr,
   input  logic [31:0] clint_addr,
   input  logic [31:0] clint_wdata,
   input  logic [3:0]  clint_wstrb,
   output logic [31:0] clint_rdata,
   output logic        clint_ready,
   output logic        timer_irq,
   output logic        soft_irq
);

   logic [63:0] mtime, mtime_d, mtime_tick;
   logic [63:0] mtimecmp, mtimecmp_d;
   logic        msip, msip_d;
   logic        tick;
   logic [31:0] off_full, rd_val;
   logic [15:0] off;
   logic        wr;
   logic        unused_bits;

   clint_rtc_tick #(.RTC_DIV(RTC_DIV)) u_rtc (
      .reset   (reset),
      .clock   (clock),
      .rtc_tick(tick)
   );

   assign off_full    = clint_addr - BASE_ADDR;
   assign off         = off_full[15:0];
   assign wr          = clint_valid & (|clint_wstrb);
   assign unused_bits = ^{clint_instr, off_full[31:16]};

   assign rd_val = (off == MSIP_OFF)        ? {31'b0, msip}    :
                   (off == MTIMECMP_LO_OFF) ? mtimecmp[31:0]   :
                   (off == MTIMECMP_HI_OFF) ? mtimecmp[63:32]  :
                   (off == MTIME_LO_OFF)    ? mtime[31:0]      :
                   (off == MTIME_HI_OFF)    ? mtime[63:32]     : 32'b0;

   // A bus write to either mtime half suppresses that cycle's increment entirely.
   assign mtime_tick = tick ? mtime + 64'd1 : mtime;
   assign mtime_d = (wr && off == MTIME_LO_OFF) ?
                       {mtime[63:32], merge_bytes(mtime[31:0], clint_wdata, clint_wstrb)} :
                    (wr && off == MTIME_HI_OFF) ?
                       {merge_bytes(mtime[63:32], clint_wdata, clint_wstrb), mtime[31:0]} :
                    mtime_tick;

   assign mtimecmp_d = (wr && off == MTIMECMP_LO_OFF) ?
                          {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], clint_wdata, clint_wstrb)} :
                       (wr && off == MTIMECMP_HI_OFF) ?
                          {merge_bytes(mtimecmp[63:32], clint_wdata, clint_wstrb), mtimecmp[31:0]} :
                       mtimecmp;

   assign msip_d = (wr && off == MSIP_OFF && clint_wstrb[0]) ? clint_wdata[0] : msip;

   always_ff @(posedge clock) begin
      if (reset) begin
         mtime       <= 64'd0;
         mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip        <= 1'b0;
         timer_irq   <= 1'b0;
         soft_irq    <= 1'b0;
         clint_ready <= 1'b0;
         clint_rdata <= 32'b0;
      end else begin
         mtime       <= mtime_d;
         mtimecmp    <= mtimecmp_d;
         msip        <= msip_d;
         timer_irq   <= (mtime_d >= mtimecmp_d);
         soft_irq    <= msip;
         clint_ready <= clint_valid;
         clint_rdata <= clint_valid ? rd_val : 32'b0;
      end
   end

endmodule
